// File: rtl/point_dbl.sv
// Ed25519 point doubling (a = -1) in extended coordinates using four bit-serial modular multipliers.
// Optional macro POINT_DBL_BUSY_EN adds a busy output covering SQ, COMB, MUL and DONE.
module point_dbl #(
  parameter int N = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  input  logic [N-1:0] t,
  output logic [N-1:0] X,
  output logic [N-1:0] Y,
  output logic [N-1:0] Z,
  output logic [N-1:0] T,
`ifdef POINT_DBL_BUSY_EN
  output logic         busy,
`endif
  output logic         data_rdy
);

  localparam int CW = $clog2(N);
  localparam logic [N:0]    P    = ({{N{1'b0}}, 1'b1} << N) - (N+1)'(19);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, SQ, COMB, MUL, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          ld;
  logic [N-1:0]  ma      [4];
  logic [N-1:0]  mb      [4];
  logic [N-1:0]  acc     [4];
  logic [N-1:0]  acc_nxt [4];
  logic [N-1:0]  c_v, h_v, e_v, g_v, f_v;

  // T is redundant for this formula; fold it so the port stays connected.
  logic unused_t;
  assign unused_t = ^t;

  function automatic logic [N-1:0] mod_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= P) s = s - P;
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] mod_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[N]) d = d + P;
    return d[N-1:0];
  endfunction

  // One interleaved-multiply step: acc = 2*acc + a*b_i, both kept in [0, p-1].
  function automatic logic [N-1:0] mul_step(input logic [N-1:0] acc_in, input logic [N-1:0] a,
                                            input logic bit_in);
    return mod_add(mod_add(acc_in, acc_in), bit_in ? a : '0);
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) acc_nxt[i] = mul_step(acc[i], ma[i], mb[i][N-1]);
  end

  // acc[0..3] hold A, B, z^2, S at the end of SQ.
  always_comb begin
    c_v = mod_add(acc[2], acc[2]);
    h_v = mod_add(acc[0], acc[1]);
    e_v = mod_sub(h_v, acc[3]);
    g_v = mod_sub(acc[0], acc[1]);
    f_v = mod_add(c_v, g_v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ld       <= 1'b0;
      data_rdy <= 1'b0;
      X        <= '0;
      Y        <= '0;
      Z        <= '0;
      T        <= '0;
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            ma[0]    <= x;
            ma[1]    <= y;
            ma[2]    <= z;
            ma[3]    <= mod_add(x, y);
            for (int i = 0; i < 4; i++) acc[i] <= '0;
            ld       <= 1'b1;
            data_rdy <= 1'b0;
            state    <= SQ;
          end
        end
        SQ: begin
          // First SQ cycle copies the squaring operands into the multiplier shift registers.
          if (ld) begin
            for (int i = 0; i < 4; i++) mb[i] <= ma[i];
            ld  <= 1'b0;
            cnt <= LAST;
          end else begin
            for (int i = 0; i < 4; i++) begin
              acc[i] <= acc_nxt[i];
              mb[i]  <= mb[i] << 1;
            end
            if (cnt == '0) state <= COMB;
            else           cnt   <= cnt - 1'b1;
          end
        end
        COMB: begin
          ma[0] <= e_v;  mb[0] <= f_v;
          ma[1] <= g_v;  mb[1] <= h_v;
          ma[2] <= e_v;  mb[2] <= h_v;
          ma[3] <= f_v;  mb[3] <= g_v;
          for (int i = 0; i < 4; i++) acc[i] <= '0;
          cnt   <= LAST;
          state <= MUL;
        end
        MUL: begin
          for (int i = 0; i < 4; i++) begin
            acc[i] <= acc_nxt[i];
            mb[i]  <= mb[i] << 1;
          end
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          X        <= acc[0];
          Y        <= acc[1];
          T        <= acc[2];
          Z        <= acc[3];
          data_rdy <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef POINT_DBL_BUSY_EN
  always_ff @(posedge clk) begin
    if (rst)                      busy <= 1'b0;
    else if (state == IDLE && en) busy <= 1'b1;
    else if (state == DONE)       busy <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_point_dbl.sv
// Directed bench for point_dbl: identity, base point, projective input, busy, reset and back-to-back.
module tb_point_dbl;

  localparam logic [255:0] P  = (256'd1 << 255) - 256'd19;
  localparam logic [255:0] PM1 = P - 256'd1;
  localparam logic [255:0] D  = 256'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3;
  localparam logic [255:0] BX = 256'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
  localparam logic [255:0] BY = 256'h6666666666666666666666666666666666666666666666666666666666666658;
  localparam logic [255:0] BT = 256'h67875f0fd78b766566ea4e8e64abe37d20f09f80775152f56dde8ab3a5b7dda3;
  localparam logic [255:0] AX = 256'h36ab384c9f5a046c3d043b7d1833e7ac080d8e4515d7a45f83c5a14e2843ce0e;
  localparam logic [255:0] AY = 256'h2260cdf3092329c21da25ee8c9a21f5697390f51643851560e5f46ae6af8a3c9;
  localparam logic [255:0] QX = 256'h3b6f8891960f6ad45776d1e1213c1bd9de44f888163a76921515e6cf9f3fd67e;
  localparam logic [255:0] QY = 256'h336d9ece4cdb30925921f40f14dab827d6e156675107378db6d34c9a874a007e;
  localparam logic [255:0] QZ = 256'h59e4ea1a52a20ea2fd9cb81712f675b450b27bff31b598ba722d5b0bf61c8608;
  localparam logic [255:0] QT = 256'h1f6e08da2d298daafc6ea6fedd5e07c172749500483d139bc532c7e392cad989;

  logic         clk, rst, en, rdy;
  logic [254:0] xi, yi, zi, ti, ox, oy, oz, ot;
`ifdef POINT_DBL_BUSY_EN
  logic         busy;
`endif
  int passed = 0, total = 0, fails = 0, cyc = 0;
  logic [255:0] ex, ey, ez, et, lhs, rhs, rx, ry, rz, rt;
  logic         saw_rdy;

  point_dbl #(.N(255)) dut (
    .clk(clk), .rst(rst), .en(en), .x(xi), .y(yi), .z(zi), .t(ti),
    .X(ox), .Y(oy), .Z(oz), .T(ot),
`ifdef POINT_DBL_BUSY_EN
    .busy(busy),
`endif
    .data_rdy(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] s;
    s = a + b;
    if (s >= P) s = s - P;
    return s;
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? a - b : a + P - b;
  endfunction

  // Full product, then fold with 2^255 == 19 (mod p).
  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] v;
    v = {256'd0, a} * {256'd0, b};
    for (int k = 0; k < 3; k++) v = {257'd0, v[254:0]} + (v >> 255) * 512'd19;
    if (v >= {256'd0, P}) v = v - {256'd0, P};
    if (v >= {256'd0, P}) v = v - {256'd0, P};
    return v[255:0];
  endfunction

  task automatic model_dbl(input logic [255:0] x, input logic [255:0] y, input logic [255:0] z,
                           output logic [255:0] x3, output logic [255:0] y3,
                           output logic [255:0] z3, output logic [255:0] t3);
    logic [255:0] a, b, c, s, h, e, g, f;
    a = fmul(x, x);
    b = fmul(y, y);
    c = fadd(fmul(z, z), fmul(z, z));
    s = fmul(fadd(x, y), fadd(x, y));
    h = fadd(a, b);
    e = fsub(h, s);
    g = fsub(a, b);
    f = fadd(c, g);
    x3 = fmul(e, f);
    y3 = fmul(g, h);
    t3 = fmul(e, h);
    z3 = fmul(f, g);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] c, input logic [255:0] d);
    xi = a[254:0];
    yi = b[254:0];
    zi = c[254:0];
    ti = d[254:0];
  endtask

  task automatic start(input logic [255:0] a, input logic [255:0] b,
                       input logic [255:0] c, input logic [255:0] d);
    set_in(a, b, c, d);
    en = 1'b1;
    tick;
    en = 1'b0;
    cyc = 0;
  endtask

  task wait_rdy;
    while (!rdy && cyc < 600) tick;
  endtask

  task grab;
    rx = {1'b0, ox};
    ry = {1'b0, oy};
    rz = {1'b0, oz};
    rt = {1'b0, ot};
  endtask

  task chk_curve(input string tag);
    chk({tag, "_xy_zt"}, fmul(rx, ry), fmul(rz, rt));
    lhs = fsub(fmul(ry, ry), fmul(rx, rx));
    rhs = fadd(fmul(rz, rz), fmul(D, fmul(rt, rt)));
    chk({tag, "_curve"}, lhs, rhs);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    set_in(256'd0, 256'd0, 256'd0, 256'd0);
    tick;
    tick;
    rst = 1'b0;
    grab;
    chk("rst_x", rx, 256'd0);
    chk("rst_y", ry, 256'd0);
    chk("rst_rdy", {255'd0, rdy}, 256'd0);

    // Identity point
    start(256'd0, 256'd1, 256'd1, 256'd0);
    wait_rdy;
    chk("id_lat", 256'(cyc), 256'd513);
    grab;
    chk("id_x", rx, 256'd0);
    chk("id_y", ry, PM1);
    chk("id_z", rz, PM1);
    chk("id_t", rt, 256'd0);
    tick;
    tick;
    tick;
    chk("hold_rdy", {255'd0, rdy}, 256'd1);
    chk("hold_y", {1'b0, oy}, PM1);

    // Base point, with en re-pulsed at cycles 100 and 300 using other inputs
    start(BX, BY, 256'd1, BT);
    chk("clr_rdy", {255'd0, rdy}, 256'd0);
    set_in(QX, QY, QZ, QT);
    while (cyc < 99) tick;
    en = 1'b1;
    tick;
    en = 1'b0;
    while (cyc < 299) tick;
    en = 1'b1;
    tick;
    en = 1'b0;
    wait_rdy;
    chk("bp_lat", 256'(cyc), 256'd513);
    grab;
    chk("bp_x_aff", rx, fmul(AX, rz));
    chk("bp_y_aff", ry, fmul(AY, rz));
    chk_curve("bp");

    // Reset at cycle 200, with en asserted in the same cycle
    start(QX, QY, QZ, QT);
    while (cyc < 199) tick;
    rst = 1'b1;
    en  = 1'b1;
    tick;
    rst = 1'b0;
    en  = 1'b0;
    grab;
    chk("mid_rst_x", rx, 256'd0);
    chk("mid_rst_y", ry, 256'd0);
    chk("mid_rst_z", rz, 256'd0);
    chk("mid_rst_t", rt, 256'd0);
    chk("mid_rst_rdy", {255'd0, rdy}, 256'd0);
    saw_rdy = 1'b0;
    for (int k = 0; k < 600; k++) begin
      tick;
      saw_rdy = saw_rdy | rdy;
    end
    chk("rst_no_done", {255'd0, saw_rdy}, 256'd0);
    start(256'd0, 256'd1, 256'd1, 256'd0);
    wait_rdy;
    chk("post_rst_lat", 256'(cyc), 256'd513);
    chk("post_rst_z", {1'b0, oz}, PM1);

    // Back-to-back: projective point, then identity, with en held high
    set_in(QX, QY, QZ, QT);
    en = 1'b1;
    tick;
    cyc = 0;
    set_in(256'd0, 256'd1, 256'd1, 256'd0);
    wait_rdy;
    chk("b2b_lat1", 256'(cyc), 256'd513);
    grab;
    model_dbl(QX, QY, QZ, ex, ey, ez, et);
    chk("pj_x", rx, ex);
    chk("pj_y", ry, ey);
    chk("pj_z", rz, ez);
    chk("pj_t", rt, et);
    chk_curve("pj");
    chk("pj_x_lt_p", {255'd0, rx < P}, 256'd1);
    chk("pj_y_lt_p", {255'd0, ry < P}, 256'd1);
    chk("pj_z_lt_p", {255'd0, rz < P}, 256'd1);
    chk("pj_t_lt_p", {255'd0, rt < P}, 256'd1);
    cyc = 0;
    do tick; while (!rdy && cyc < 600);
    en = 1'b0;
    chk("b2b_lat2", 256'(cyc), 256'd514);
    grab;
    chk("b2b_id_x", rx, 256'd0);
    chk("b2b_id_y", ry, PM1);
    chk("b2b_id_z", rz, PM1);
    chk("b2b_id_t", rt, 256'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/point_dbl.md
Name: point_dbl

Overview:
- Doubles a point on the Ed25519 twisted Edwards curve (a = -1), using extended projective coordinates (X:Y:Z:T), with T = XY/Z, over GF(p), p = 2^255 - 19.
- Used inside the scalar-multiplication datapath.
- Multi-cycle block: inputs are latched on `en`, results are produced after a fixed latency, and `data_rdy` flags completion.

Parameters:
- N, 255, field element width. Only 255 is supported. p is derived internally as 2^255 - 19.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  start strobe; sampled only in IDLE.
- x  in  N  input X coordinate, canonical (< p).
- y  in  N  input Y coordinate, canonical.
- z  in  N  input Z coordinate, canonical, nonzero.
- t  in  N  input T coordinate; accepted but not used by the formula.
- X  out  N  result X3.
- Y  out  N  result Y3.
- Z  out  N  result Z3.
- T  out  N  result T3.
- data_rdy  out  1  result valid.

Behaviour:
- Formula (dbl-2008-hwcd, a = -1), all arithmetic mod p:
  - A = x^2, B = y^2, C = 2*z^2, S = (x+y)^2
  - H = A+B, E = H-S, G = A-B, F = C+G
  - X3 = E*F, Y3 = G*H, T3 = E*H, Z3 = F*G
- Every intermediate value and every output is fully reduced to [0, p-1]:
  - Modular add: sum; if sum >= p, subtract p.
  - Modular sub: difference; if negative, add p.
- Four identical bit-serial interleaved modular multipliers run in parallel.
  - Each processes one multiplier bit per cycle, MSB first.
  - Per step: acc = 2*acc mod p, then add a*b_i mod p.
  - A multiply takes N cycles.
- FSM states:
  - IDLE: wait for en = 1. On en, latch x, y, z, compute xy = (x+y) mod p, and go to SQ.
  - SQ: N cycles computing A, B, z^2, S in parallel. Then go to COMB.
  - COMB: 1 cycle forming C, H, E, G, F. Then go to MUL.
  - MUL: N cycles computing X3, Y3, T3, Z3 in parallel. Then go to DONE.
  - DONE: 1 cycle registering X, Y, Z, T and setting data_rdy = 1. Then go to IDLE.
- Latency: data_rdy rises exactly 2N+3 = 513 cycles after the clock edge that sampled en = 1.
- Outputs X, Y, Z, T and data_rdy hold their values until the next completion.
  - data_rdy clears on the edge that accepts a new en.
- en outside IDLE is ignored; no queuing. Inputs may change freely after the accepting edge.
- en held high continuously: a new operation starts on the cycle after DONE (back-to-back).
- Reset (rst = 1 at a clock edge), including mid-operation:
  - FSM goes to IDLE.
  - X, Y, Z, T = 0; data_rdy = 0.
  - All internal accumulators are cleared.
  - rst has priority over en in the same cycle.
- Output is not normalized; Z3 is generally not 1.
  - Identity input (0,1,1,0) yields exactly (0, p-1, p-1, 0).

Optional Feature:
- Macro POINT_DBL_BUSY_EN.
- Defined: adds an output port busy (1 bit).
  - busy = 1 in SQ, COMB, MUL and DONE; 0 in IDLE and during reset.
- Undefined: no busy port. The rest of the behaviour is identical.

Test Plan:
- Identity: rst for 1 cycle, then x=0, y=1, z=1, t=0, en pulsed for 1 cycle.
  -> data_rdy at cycle 513; (X,Y,Z,T) = (0, p-1, p-1, 0).
- Base point doubling:
  - x = 216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a
  - y = 6666666666666666666666666666666666666666666666666666666666666658
  - z = 1
  - t = 67875f0fd78b766566ea4e8e64abe37d20f09f80775152f56dde8ab3a5b7dda3
  - -> X/Z = 36ab384c9f5a046c3d043b7d1833e7ac080d8e4515d7a45f83c5a14e2843ce0e
  - -> Y/Z = 2260cdf3092329c21da25ee8c9a21f5697390f51643851560e5f46ae6af8a3c9
  - -> X*Y == Z*T mod p
- Projective input:
  - x = 3b6f8891960f6ad45776d1e1213c1bd9de44f888163a76921515e6cf9f3fd67e
  - y = 336d9ece4cdb30925921f40f14dab827d6e156675107378db6d34c9a874a007e
  - z = 59e4ea1a52a20ea2fd9cb81712f675b450b27bff31b598ba722d5b0bf61c8608
  - t = 1f6e08da2d298daafc6ea6fedd5e07c172749500483d139bc532c7e392cad989
  - -> result matches a golden model; X*Y == Z*T mod p; result satisfies -X^2 + Y^2 = Z^2 + d*T^2 (projective form, d = Ed25519 constant); all outputs < p.
- Busy handling: en re-pulsed at cycles 100 and 300 with different inputs.
  -> ignored; the result at cycle 513 matches the first inputs.
- Reset mid-operation: rst asserted at cycle 200.
  -> next cycle X, Y, Z, T = 0 and data_rdy = 0; a new en then completes normally 513 cycles later.
- Back-to-back: en held high across two operations.
  -> second data_rdy rises exactly 514 cycles after the first; both results correct.
